// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the 4x8-bit CPU control path: opcodes, ALU selects, FSM states.
// No logic of its own; latency and backpressure are properties of the modules that import it.
// Field positions locate opcode, dest and src/imm inside the 8-bit instruction word.
package cpu_control_fsm_pkg;

    localparam logic [3:0] OP_MOV = 4'b1000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 2;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;

    typedef enum logic [1:0] {
        ALU_PASS_IMM = 2'b00,
        ALU_ADD      = 2'b01,
        ALU_SUB      = 2'b10,
        ALU_NOT      = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic    legal;
        alu_op_e alu_op;
    } dec_t;

    // Undefined opcodes fall back to PASS_IMM so the datapath sees a benign select.
    function automatic dec_t decode_op(input logic [3:0] opc);
        dec_t d;
        d.legal  = 1'b1;
        d.alu_op = ALU_PASS_IMM;
        case (opc)
            OP_MOV:  d.alu_op = ALU_PASS_IMM;
            OP_ADD:  d.alu_op = ALU_ADD;
            OP_SUB:  d.alu_op = ALU_SUB;
            OP_NOT:  d.alu_op = ALU_NOT;
            default: d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Board-input and datapath-control bundle between the sequencer and its neighbours.
// Pure wiring, zero latency; no backpressure (datapath always accepts controls).
// master = sequencer side, slave = board/datapath side.
interface cpu_control_fsm_if;

    logic [7:0] trainer_dip;
    logic       activate_button;
    logic [7:0] ir;
    logic [1:0] rf_rd_a;
    logic [1:0] rf_rd_b;
    logic [1:0] rf_wr_addr;
    logic       rf_we;
    logic [1:0] alu_op;
    logic [1:0] imm;
    logic       busy;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  trainer_dip, activate_button,
        output ir, rf_rd_a, rf_rd_b, rf_wr_addr, rf_we, alu_op, imm,
               busy, instr_done, illegal_op
    );

    modport slave (
        output trainer_dip, activate_button,
        input  ir, rf_rd_a, rf_rd_b, rf_wr_addr, rf_we, alu_op, imm,
               busy, instr_done, illegal_op
    );

endinterface

// File: rtl/cpu_control_fsm_button_conditioner.sv
// Button conditioner: 2-flop sync, optional debounce (CTRL_DEBOUNCE_EN), rising-edge pulse.
// Latency: pulse 2 cycles after input rises (plus DEBOUNCE_CYCLES when debounce is enabled).
// No backpressure: one single-cycle press_pulse per accepted press; a new press needs a release.
module cpu_control_fsm_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press_pulse
);

    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef CTRL_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    // Any low sample restarts the count; release is taken immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (!sync2_q) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (!stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = stable_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press_pulse = level & ~level_q;

endmodule

// File: rtl/cpu_control_fsm.sv
// Instruction sequencer: FETCH-DECODE-EXEC-WB-DONE per button press (debounce via CTRL_DEBOUNCE_EN).
// Latency: go at N -> rf_we at N+4, instr_done at N+5, busy N+1..N+5.
// Presses arriving while busy are dropped, never queued; trainer_dip sampled only in FETCH.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_control_fsm_if.master     ctl
);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] ir_q;
    logic       go;
    dec_t       dec;

    cpu_control_fsm_button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (ctl.activate_button),
        .press_pulse (go)
    );

    assign dec = decode_op(ir_q[OPC_MSB:OPC_LSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH) begin
                ir_q <= ctl.trainer_dip;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_DONE;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Decode outputs follow ir, which only changes leaving FETCH, so they hold while idle.
    always_comb begin
        ctl.ir         = ir_q;
        ctl.rf_rd_a    = ir_q[RD_MSB:RD_LSB];
        ctl.rf_rd_b    = ir_q[RS_MSB:RS_LSB];
        ctl.imm        = ir_q[RS_MSB:RS_LSB];
        ctl.alu_op     = dec.alu_op;
        ctl.busy       = (state_q != ST_IDLE);
        ctl.rf_we      = (state_q == ST_WB);
        ctl.rf_wr_addr = 2'b00;
        ctl.instr_done = (state_q == ST_DONE);
        ctl.illegal_op = (state_q == ST_DECODE) && !dec.legal;
        if (state_q == ST_WB) begin
            ctl.rf_wr_addr = ir_q[RD_MSB:RD_LSB];
        end
    end

endmodule
